// File: rtl/instr_decode_stage.sv
// instr_decode_stage: 2-entry skid-buffered decode stage that feeds the immediate sign-extension unit.
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  synchronous discard of buffered and incoming instructions
//   in_valid/in_ready      fetch handshake; in_ready is registered (skid entry empty)
//   in_instr, in_pc        instruction word and its PC
//   out_valid/out_ready    execute handshake
//   out_pc                 PC of the decoded instruction
//   out_opcode             instr[15:10]
//   out_reg_sel            instr[9], X/Y register select
//   out_imm                instr[8:0], raw immediate for the sign-extension unit
//   out_ext_sel            extension selector for the sign-extension unit
//   out_has_imm            instruction uses the immediate
//   out_illegal            only with DECODE_ILLEGAL_TRAP_EN: class 00 opcode above 0xB
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal-opcode flag and stall until flush).
module instr_decode_stage #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int IMM_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [5:0]         out_opcode,
    output logic               out_reg_sel,
    output logic [IMM_W-1:0]   out_imm,
    output logic [1:0]         out_ext_sel,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic               out_illegal,
`endif
    output logic               out_has_imm
);
    logic               main_vld, skid_vld;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_pc, skid_pc;
    logic               accept, pop, to_skid, skid_next, trap_next;
    logic [5:0]         op;
    assign accept    = in_valid & in_ready;
    assign pop       = main_vld & out_ready;
    // a new word parks in the skid entry only when main stays occupied this cycle
    assign to_skid   = accept & main_vld & ~pop;
    assign skid_next = to_skid | (skid_vld & ~pop);
    assign op        = main_instr[15:10];
    assign out_valid   = main_vld;
    assign out_pc      = main_pc;
    assign out_opcode  = op;
    assign out_reg_sel = main_instr[9];
    assign out_imm     = main_instr[IMM_W-1:0];
    assign out_has_imm = op[5:4] != 2'b00;
    assign out_ext_sel = op[5:4] == 2'b10 ? 2'b01 : op[5:4] == 2'b11 ? {1'b1, op[3]} : 2'b00;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic trap;
    assign out_illegal = op[5:4] == 2'b00 && op[3:0] > 4'hB;
    // once an illegal bundle leaves, fetch is held off until the flush that redirects it
    assign trap_next   = trap | (pop & out_illegal);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap <= 1'b0;
        else
            trap <= flush ? 1'b0 : trap_next;
    end
`else
    assign trap_next = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready   <= 1'b1;
            main_instr <= '0;
            main_pc    <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (accept && (!main_vld || pop)) begin
                main_instr <= in_instr;
                main_pc    <= in_pc;
            end else if (pop && skid_vld) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
            end
            if (to_skid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end
            main_vld <= accept | skid_vld | (main_vld & ~pop);
            skid_vld <= skid_next;
            in_ready <= ~skid_next & ~trap_next;
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed bench with a queue-based reference model for instr_decode_stage.
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_reg_sel, out_has_imm;
    logic [15:0] in_instr, in_pc, out_pc;
    logic [5:0]  out_opcode;
    logic [8:0]  out_imm;
    logic [1:0]  out_ext_sel;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        out_illegal;
`endif
    int n_cmp = 0, n_bad = 0, dut_pops = 0, pops0;
    logic [15:0] last_pc;

    typedef struct {logic [15:0] pc; logic [15:0] instr;} ent_t;
    ent_t q[$];
    bit   m_trap;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_reg_sel(out_reg_sel), .out_imm(out_imm),
        .out_ext_sel(out_ext_sel),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .out_illegal(out_illegal),
`endif
        .out_has_imm(out_has_imm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [15:0] w);
`ifdef DECODE_ILLEGAL_TRAP_EN
        return w[15:14] == 2'd0 && w[13:10] > 4'd11;
`else
        return 1'b0;
`endif
    endfunction

    // expected selector from the instruction class table
    function automatic logic [1:0] exp_ext(input logic [15:0] w);
        case (w[15:14])
            2'd2:    return 2'd1;
            2'd3:    return w[13] ? 2'd3 : 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // reference model: the stage is a FIFO of at most two words
    always @(posedge clk or negedge rst_n) begin
        bit acc, pop;
        if (!rst_n) begin
            q.delete();
            m_trap = 0;
        end else begin
            acc = in_valid && q.size() < 2 && !m_trap;
            pop = q.size() != 0 && out_ready;
            if (flush) begin
                q.delete();
                m_trap = 0;
            end else begin
                if (pop) begin
                    if (is_illegal(q[0].instr)) m_trap = 1;
                    void'(q.pop_front());
                end
                if (acc) q.push_back('{in_pc, in_instr});
            end
        end
    end

    always @(posedge clk)
        if (rst_n && out_valid && out_ready) begin
            dut_pops++;
            last_pc = out_pc;
        end

    always @(negedge clk)
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2 && !m_trap);
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_opcode", out_opcode, q[0].instr[15:10]);
                chk("out_reg_sel", out_reg_sel, q[0].instr[9]);
                chk("out_imm", out_imm, q[0].instr[8:0]);
                chk("out_ext_sel", out_ext_sel, exp_ext(q[0].instr));
                chk("out_has_imm", out_has_imm, q[0].instr[15:14] != 2'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
                chk("out_illegal", out_illegal, is_illegal(q[0].instr));
`endif
            end
        end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    logic [15:0] vec [4] = '{16'h41FF, 16'h8080, 16'hC015, 16'hE1FF};
    logic [5:0]  vop [4] = '{6'h10, 6'h20, 6'h30, 6'h38};
    logic [8:0]  vimm[4] = '{9'h1FF, 9'h080, 9'h015, 9'h1FF};
    logic [1:0]  vext[4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_ext", {out_opcode, out_reg_sel, out_ext_sel, out_has_imm}, 0);
        rst_n = 1;
        @(negedge clk);
        // class decode, one word per cycle
        out_ready = 1;
        in_valid = 1; in_instr = vec[0]; in_pc = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dec_valid", out_valid, 1);
            chk("dec_opcode", out_opcode, vop[i]);
            chk("dec_reg", out_reg_sel, 0);
            chk("dec_imm", out_imm, vimm[i]);
            chk("dec_ext", out_ext_sel, vext[i]);
            chk("dec_has_imm", out_has_imm, 1);
            if (i < 3) begin in_instr = vec[i+1]; in_pc = 16'h0012 + 16'(2*i); end
            else in_valid = 0;
        end
        @(negedge clk);
        // backpressure
        out_ready = 0;
        in_valid = 1; in_instr = 16'h0001; in_pc = 16'h0100;
        @(negedge clk);
        in_instr = 16'h0002; in_pc = 16'h0102;
        @(negedge clk);
        in_valid = 0;
        repeat (3) begin
            chk("bp_ready", in_ready, 0);
            chk("bp_hold_imm", out_imm, 9'h001);
            chk("bp_hold_pc", out_pc, 16'h0100);
            @(negedge clk);
        end
        pops0 = dut_pops;
        out_ready = 1;
        @(negedge clk);
        chk("bp_second_pc", out_pc, 16'h0102);
        chk("bp_second_imm", out_imm, 9'h002);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        chk("bp_pop_count", dut_pops - pops0, 2);
        // asynchronous reset while full
        out_ready = 0;
        in_valid = 1; in_instr = 16'h4005; in_pc = 16'h0200;
        @(negedge clk);
        in_instr = 16'h4006; in_pc = 16'h0202;
        @(negedge clk);
        in_valid = 0;
        chk("pre_rst_ready", in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_pc", out_pc, 0);
        chk("arst_imm", out_imm, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        // flush while full with a concurrent incoming word
        in_valid = 1; in_instr = 16'h0003; in_pc = 16'h0300;
        @(negedge clk);
        in_instr = 16'h0004; in_pc = 16'h0302;
        @(negedge clk);
        flush = 1; in_instr = 16'h8080; in_pc = 16'h0304; out_ready = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        pops0 = dut_pops;
        repeat (3) @(negedge clk);
        chk("flush_no_ghost", dut_pops - pops0, 0);
        // throughput: 100 words back to back
        pops0 = dut_pops;
        in_valid = 1;
        for (int k = 0; k < 100; k++) begin
            in_instr = 16'h4000 | 16'((k * 37) & 16'h3FFF);
            in_pc = 16'h1000 + 16'(2*k);
            @(negedge clk);
        end
        in_valid = 0;
        @(negedge clk);
        chk("tput_count", dut_pops - pops0, 100);
        chk("tput_last_pc", last_pc, 16'h10C6);
        // illegal-looking R-type word
        in_valid = 1; in_instr = 16'h3C00; in_pc = 16'h2000;
        @(negedge clk);
        in_valid = 0;
        chk("ill_opcode", out_opcode, 6'h0F);
        chk("ill_ext", out_ext_sel, 0);
        chk("ill_has_imm", out_has_imm, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ill_flag", out_illegal, 1);
`endif
        in_valid = 1; in_instr = 16'h8080; in_pc = 16'h2002;
        repeat (3) begin
            @(negedge clk);
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk("ill_stall", in_ready, 0);
`else
            chk("ill_no_stall", in_ready, 1);
`endif
        end
        flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("ill_flush_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Pipeline stage directly upstream of the immediate sign-extension unit.
- Accepts 16-bit instruction words plus PC from fetch over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Decodes each word into opcode, register select, raw 9-bit immediate field and the 2-bit extension selector that the sign-extension unit consumes.
- Passes the decoded bundle downstream to execute with full throughput and a branch-flush input.

Parameters:
- INSTR_W, 16, instruction word width; fixed field map below assumes 16.
- PC_W, 16, program counter width carried alongside each instruction.
- IMM_W, 9, raw immediate field width, instr[IMM_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discard all buffered and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals skid-entry-empty, registered.
- in_instr  in  INSTR_W  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_W  PC of the decoded instruction.
- out_opcode  out  6  instr[15:10].
- out_reg_sel  out  1  instr[9] (X/Y register select).
- out_imm  out  IMM_W  instr[8:0], unmodified; drives the sign-extension unit imm input.
- out_ext_sel  out  2  extension selector; drives the sign-extension unit sel input.
- out_has_imm  out  1  instruction uses the immediate.

Behaviour:
- Reset (async, rst_n=0): both entries invalid; out_valid=0, in_ready=1, all data outputs 0. Reset mid-transfer drops all content.
- Storage: main register (drives out_*) and skid register. Occupancy states:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE; word goes to main.
  - ONE + accept and no pop -> FULL; word goes to skid.
  - ONE + accept + pop -> ONE; new word replaces main.
  - ONE + pop only -> EMPTY.
  - FULL + pop -> ONE; skid moves to main. No accept is possible in FULL (in_ready=0).
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL.
- Stability: out_* hold stable while out_valid=1 and out_ready=0.
- Decode is combinational from stored instr; class = opcode[5:4]:
  - 00 R-type: ext_sel=00, has_imm=0.
  - 01 branch: ext_sel=00 (9b signed), has_imm=1.
  - 10 ALU-imm: ext_sel=01 (8b signed), has_imm=1.
  - 11 memory: opcode[3]=0 gives ext_sel=10 (5b signed offset); opcode[3]=1 gives ext_sel=11 (9b zero-extend). has_imm=1 in both cases.
- out_imm always equals instr[8:0], whatever the class.
- Flush has priority over everything. Next state is EMPTY, in_ready=1, out_valid=0. An accept in the same cycle is discarded, and a pop in the same cycle is still counted as consumed by execute.
- Simultaneous flush and reset: reset wins.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output out_illegal (1 bit), set for class 00 with opcode[3:0] > 4'hB.
  - An illegal bundle is still delivered with has_imm=0, ext_sel=00.
  - in_ready is forced to 0 from the cycle the illegal bundle is popped until flush is asserted.
- When undefined: no out_illegal port; illegal opcodes decode as ordinary R-type and never stall.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 entries held -> out_valid=0 and in_ready=1 immediately, asynchronously; outputs 0.
- Class decode, out_ready=1, one per cycle, each appearing 1 cycle after accept:
  - 0x41FF -> opcode 0x10, reg 0, imm 0x1FF, ext_sel 00.
  - 0x8080 -> imm 0x080, ext_sel 01.
  - 0xC015 -> imm 0x015, ext_sel 10.
  - 0xE1FF -> ext_sel 11.
  - All four with has_imm=1.
- Backpressure: out_ready=0, push 0x0001 then 0x0002 -> state FULL, in_ready=0, out holds 0x0001. Release out_ready -> 0x0001 then 0x0002 delivered in order, nothing lost or duplicated.
- Flush: FULL state, flush=1 with in_valid=1 (0x8080) -> next cycle out_valid=0, in_ready=1, 0x8080 never appears.
- Throughput: 100 back-to-back words with out_ready=1 -> 100 bundles in 101 cycles, PCs in order.
- With DECODE_ILLEGAL_TRAP_EN defined, 0x3C00 -> out_illegal=1, in_ready stays 0 after pop until flush; without the macro, same word decodes as R-type, ext_sel 00, has_imm 0, no stall.
